// File: rtl/store_commit_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : store_commit_buffer_pkg
//  Description : Shared types and sizing constants for the store commit
//                buffer: data/mask/tag types, the buffer entry record and
//                the wrap-bit pointer type.
//  Revision    : 1.0 - initial release
// ============================================================================
package store_commit_buffer_pkg;

    // Buffer configuration. SB_DEPTH must be a power of two, minimum 2.
    localparam int XLEN      = 32;
    localparam int ROB_TAG_W = 5;
    localparam int SB_DEPTH  = 8;
    localparam int MASK_W    = XLEN / 8;
    localparam int SB_IDX_W  = $clog2(SB_DEPTH);
    localparam int SB_PTR_W  = SB_IDX_W + 1;

    typedef logic [XLEN-1:0]      xlen_data_t;
    typedef logic [MASK_W-1:0]    byte_mask_t;
    typedef logic [ROB_TAG_W-1:0] rob_tag_t;
    // Pointer = entry index plus one wrap bit (MSB) to tell full from empty.
    typedef logic [SB_PTR_W-1:0]  sb_ptr_t;
    typedef logic [SB_IDX_W-1:0]  sb_idx_t;

    typedef struct packed {
        logic       valid;
        logic       committed;
        xlen_data_t addr;
        xlen_data_t data;
        byte_mask_t mask;
        rob_tag_t   tag;
        logic       nonidem;
    } sb_entry_t;

    // Two byte addresses fall in the same aligned word.
    function automatic logic same_word(input xlen_data_t a, input xlen_data_t b);
        return a[XLEN-1:2] == b[XLEN-1:2];
    endfunction

endpackage : store_commit_buffer_pkg
`default_nettype wire

// File: rtl/store_commit_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : store_commit_buffer_if
//  Description : D-cache drain channel of the store commit buffer.
//                master : buffer side (drives request + payload)
//                slave  : D-cache side (drives acknowledge)
//  Ports       : dc_req_o, dc_addr_o, dc_data_o, dc_mask_o, dc_ack_i
//  Revision    : 1.0 - initial release
// ============================================================================
interface store_commit_buffer_if;
    import store_commit_buffer_pkg::*;

    logic       dc_req_o;
    xlen_data_t dc_addr_o;
    xlen_data_t dc_data_o;
    byte_mask_t dc_mask_o;
    logic       dc_ack_i;

    modport master (
        output dc_req_o,
        output dc_addr_o,
        output dc_data_o,
        output dc_mask_o,
        input  dc_ack_i
    );

    modport slave (
        input  dc_req_o,
        input  dc_addr_o,
        input  dc_data_o,
        input  dc_mask_o,
        output dc_ack_i
    );

endinterface : store_commit_buffer_if
`default_nettype wire

// File: rtl/store_commit_buffer_sb_forward_search.sv
`default_nettype none
// ============================================================================
//  Module      : sb_forward_search
//  Description : Combinational store-to-load forwarding search. Scans the
//                entry array youngest-first, starting at tail-1 and wrapping
//                back towards head, and returns the first matching entry.
//  Ports       : entries_i          - buffer entry array
//                tail_i             - tail pointer (priority start)
//                find_addr_i/mask_i - load address and byte mask
//                hit_o/data_o/mask_o - youngest match; zero when no match
//  Revision    : 1.0 - initial release
// ============================================================================
module sb_forward_search
    import store_commit_buffer_pkg::*;
(
    input  sb_entry_t  entries_i [SB_DEPTH],
    input  sb_ptr_t    tail_i,
    input  xlen_data_t find_addr_i,
    input  byte_mask_t find_mask_i,
    output logic       hit_o,
    output xlen_data_t data_o,
    output byte_mask_t mask_o
);

    always_comb begin
        sb_idx_t    idx;
        byte_mask_t ovl;
        hit_o  = 1'b0;
        data_o = '0;
        mask_o = '0;
        idx    = '0;
        ovl    = '0;
        // k = 1 is the youngest slot (tail-1); k = SB_DEPTH lands on tail
        // itself, which only holds a valid entry when the buffer is full.
        for (int k = 1; k <= SB_DEPTH; k++) begin
            idx = tail_i[SB_IDX_W-1:0] - k[SB_IDX_W-1:0];
            ovl = entries_i[idx].mask & find_mask_i;
            if (!hit_o && entries_i[idx].valid &&
                same_word(entries_i[idx].addr, find_addr_i) && (ovl != '0)) begin
                hit_o  = 1'b1;
                data_o = entries_i[idx].data;
                mask_o = ovl;
            end
        end
    end

endmodule : sb_forward_search
`default_nettype wire

// File: rtl/store_commit_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : store_commit_buffer
//  Description : In-order buffer of executed stores. Entries are allocated
//                at tail, marked committed in order at cmt by the ROB, and
//                drained from head to the D-cache over a req/ack channel.
//                Provides youngest-first load forwarding and a registered
//                "non-idempotent store present" flag.
//  Ports       : clk_i, rst_i            - clock, sync active-high reset
//                flush_i                 - drop all uncommitted stores
//                instr_valid_i, store_allocate_*, store_non_idempotent_region_i
//                                        - store allocation from the LSU
//                commit_valid_i, commit_rob_tag_i - in-order ROB commit
//                sb_load_find_*, sb_load_forward_* - load forwarding
//                non_idempotent_instr_exists_o, full_o, empty_o,
//                commit_mismatch_o       - status
//                dc                      - D-cache drain channel (master)
//  Revision    : 1.0 - initial release
// ============================================================================
module store_commit_buffer
    import store_commit_buffer_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       flush_i,
    input  logic       instr_valid_i,
    input  logic       store_allocate_i,
    input  xlen_data_t store_allocate_addr_i,
    input  xlen_data_t store_allocate_data_i,
    input  byte_mask_t store_allocate_mask_i,
    input  rob_tag_t   store_allocate_rob_tag_i,
    input  logic       store_non_idempotent_region_i,
    input  logic       commit_valid_i,
    input  rob_tag_t   commit_rob_tag_i,
    input  xlen_data_t sb_load_find_addr_i,
    input  byte_mask_t sb_load_find_mask_i,
    output logic       sb_load_forward_hit_o,
    output xlen_data_t sb_load_forward_data_o,
    output byte_mask_t sb_load_forward_mask_o,
    output logic       non_idempotent_instr_exists_o,
    output logic       full_o,
    output logic       empty_o,
    output logic       commit_mismatch_o,
    store_commit_buffer_if.master dc
);

    sb_entry_t entries_q [SB_DEPTH];
    sb_entry_t entries_d [SB_DEPTH];
    sb_ptr_t   head_q, head_d;
    sb_ptr_t   cmt_q,  cmt_d;
    sb_ptr_t   tail_q, tail_d;
    logic      mismatch_q, mismatch_d;
    logic      nonidem_q,  nonidem_d;

    sb_idx_t   w_head_idx;
    sb_idx_t   w_cmt_idx;
    sb_idx_t   w_tail_idx;
    logic      w_alloc;
    logic      w_commit_do;
    logic      w_pop;
    sb_entry_t w_head;

    assign w_head_idx = head_q[SB_IDX_W-1:0];
    assign w_cmt_idx  = cmt_q[SB_IDX_W-1:0];
    assign w_tail_idx = tail_q[SB_IDX_W-1:0];
    assign w_head     = entries_q[w_head_idx];

    // Status is decoded from registered pointers only, so a same-cycle pop
    // never makes room for a same-cycle allocate.
    assign empty_o = (tail_q == head_q);
    assign full_o  = (tail_q[SB_IDX_W] != head_q[SB_IDX_W]) &&
                     (w_tail_idx == w_head_idx);

    assign w_alloc     = instr_valid_i && store_allocate_i && !full_o && !flush_i;
    assign w_commit_do = commit_valid_i && (cmt_q != tail_q);

    // Drain channel: payload is zero unless a request is up.
    assign dc.dc_req_o  = w_head.valid && w_head.committed;
    assign dc.dc_addr_o = dc.dc_req_o ? {w_head.addr[XLEN-1:2], 2'b00} : '0;
    assign dc.dc_data_o = dc.dc_req_o ? w_head.data : '0;
    assign dc.dc_mask_o = dc.dc_req_o ? w_head.mask : '0;
    assign w_pop        = dc.dc_req_o && dc.dc_ack_i;

    // A commit with nothing uncommitted, or with the wrong tag, is flagged;
    // a wrong-tag commit still retires the entry at cmt.
    assign mismatch_d = commit_valid_i &&
                        (!w_commit_do || (entries_q[w_cmt_idx].tag != commit_rob_tag_i));

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        cmt_d     = cmt_q;
        tail_d    = tail_q;

        if (w_pop) begin
            entries_d[w_head_idx].valid = 1'b0;
            head_d = head_q + sb_ptr_t'(1);
        end

        if (w_commit_do) begin
            entries_d[w_cmt_idx].committed = 1'b1;
            cmt_d = cmt_q + sb_ptr_t'(1);
        end

        // Flush sees the same-cycle commit already applied, so that store
        // survives; everything still uncommitted is dropped.
        if (flush_i) begin
            for (int i = 0; i < SB_DEPTH; i++) begin
                if (entries_d[i].valid && !entries_d[i].committed) begin
                    entries_d[i].valid = 1'b0;
                end
            end
            tail_d = cmt_d;
        end else if (w_alloc) begin
            entries_d[w_tail_idx].valid     = 1'b1;
            entries_d[w_tail_idx].committed = 1'b0;
            entries_d[w_tail_idx].addr      = store_allocate_addr_i;
            entries_d[w_tail_idx].data      = store_allocate_data_i;
            entries_d[w_tail_idx].mask      = store_allocate_mask_i;
            entries_d[w_tail_idx].tag       = store_allocate_rob_tag_i;
            entries_d[w_tail_idx].nonidem   = store_non_idempotent_region_i;
            tail_d = tail_q + sb_ptr_t'(1);
        end
    end

    // Taken from next-state entries so the flag rises together with the
    // entry becoming visible and falls in the cycle after its ack.
    always_comb begin
        nonidem_d = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            nonidem_d = nonidem_d | (entries_d[i].valid & entries_d[i].nonidem);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < SB_DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q     <= '0;
            cmt_q      <= '0;
            tail_q     <= '0;
            mismatch_q <= 1'b0;
            nonidem_q  <= 1'b0;
        end else begin
            for (int i = 0; i < SB_DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
            head_q     <= head_d;
            cmt_q      <= cmt_d;
            tail_q     <= tail_d;
            mismatch_q <= mismatch_d;
            nonidem_q  <= nonidem_d;
        end
    end

    assign commit_mismatch_o             = mismatch_q;
    assign non_idempotent_instr_exists_o = nonidem_q;

    sb_forward_search u_fwd (
        .entries_i   (entries_q),
        .tail_i      (tail_q),
        .find_addr_i (sb_load_find_addr_i),
        .find_mask_i (sb_load_find_mask_i),
        .hit_o       (sb_load_forward_hit_o),
        .data_o      (sb_load_forward_data_o),
        .mask_o      (sb_load_forward_mask_o)
    );

endmodule : store_commit_buffer
`default_nettype wire

// File: tb/tb_store_commit_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_commit_buffer
//  Description : Directed self-checking bench for store_commit_buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_store_commit_buffer;
    import store_commit_buffer_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       instr_valid;
    logic       st_alloc;
    xlen_data_t st_addr;
    xlen_data_t st_data;
    byte_mask_t st_mask;
    rob_tag_t   st_tag;
    logic       st_ni;
    logic       cm_valid;
    rob_tag_t   cm_tag;
    xlen_data_t find_addr;
    byte_mask_t find_mask;
    logic       fwd_hit;
    xlen_data_t fwd_data;
    byte_mask_t fwd_mask;
    logic       ni_exists;
    logic       full;
    logic       empty;
    logic       cm_mismatch;

    int n_cmp = 0;
    int n_err = 0;

    store_commit_buffer_if dcif ();

    store_commit_buffer dut (
        .clk_i                         (clk),
        .rst_i                         (rst),
        .flush_i                       (flush),
        .instr_valid_i                 (instr_valid),
        .store_allocate_i              (st_alloc),
        .store_allocate_addr_i         (st_addr),
        .store_allocate_data_i         (st_data),
        .store_allocate_mask_i         (st_mask),
        .store_allocate_rob_tag_i      (st_tag),
        .store_non_idempotent_region_i (st_ni),
        .commit_valid_i                (cm_valid),
        .commit_rob_tag_i              (cm_tag),
        .sb_load_find_addr_i           (find_addr),
        .sb_load_find_mask_i           (find_mask),
        .sb_load_forward_hit_o         (fwd_hit),
        .sb_load_forward_data_o        (fwd_data),
        .sb_load_forward_mask_o        (fwd_mask),
        .non_idempotent_instr_exists_o (ni_exists),
        .full_o                        (full),
        .empty_o                       (empty),
        .commit_mismatch_o             (cm_mismatch),
        .dc                            (dcif)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input xlen_data_t a, input xlen_data_t d, input byte_mask_t m,
                         input rob_tag_t t, input logic ni);
        instr_valid = 1'b1; st_alloc = 1'b1;
        st_addr = a; st_data = d; st_mask = m; st_tag = t; st_ni = ni;
        tick();
        instr_valid = 1'b0; st_alloc = 1'b0; st_ni = 1'b0;
    endtask

    task automatic commit(input rob_tag_t t);
        cm_valid = 1'b1; cm_tag = t;
        tick();
        cm_valid = 1'b0;
    endtask

    task automatic ack();
        dcif.dc_ack_i = 1'b1;
        tick();
        dcif.dc_ack_i = 1'b0;
    endtask

    task automatic search(input xlen_data_t a, input byte_mask_t m);
        find_addr = a; find_mask = m;
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; instr_valid = 1'b0; st_alloc = 1'b0;
        st_addr = '0; st_data = '0; st_mask = '0; st_tag = '0; st_ni = 1'b0;
        cm_valid = 1'b0; cm_tag = '0; find_addr = '0; find_mask = '0;
        dcif.dc_ack_i = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // ---- reset state ----
        check_eq("rst_empty",    empty,          1);
        check_eq("rst_full",     full,           0);
        check_eq("rst_req",      dcif.dc_req_o,  0);
        check_eq("rst_addr",     dcif.dc_addr_o, 0);
        check_eq("rst_hit",      fwd_hit,        0);
        check_eq("rst_mismatch", cm_mismatch,    0);
        check_eq("rst_ni",       ni_exists,      0);

        // ---- single store: allocate, commit, stalled drain, ack ----
        alloc(32'h1000, 32'hAABBCCDD, 4'hF, 5'd3, 1'b0);
        check_eq("t1_not_empty", empty,         0);
        check_eq("t1_no_req",    dcif.dc_req_o, 0);
        commit(5'd3);
        check_eq("t1_mismatch0", cm_mismatch, 0);
        for (int c = 0; c < 3; c++) begin
            check_eq("t1_req",  dcif.dc_req_o,  1);
            check_eq("t1_addr", dcif.dc_addr_o, 32'h1000);
            check_eq("t1_data", dcif.dc_data_o, 32'hAABBCCDD);
            check_eq("t1_mask", dcif.dc_mask_o, 4'hF);
            tick();
        end
        ack();
        check_eq("t1_empty", empty,         1);
        check_eq("t1_req0",  dcif.dc_req_o, 0);

        // ---- fill to full, dropped 9th, pop frees one, back-to-back drain ----
        for (int i = 0; i < 8; i++) begin
            alloc(32'h100 + 32'(4 * i), 32'h50 + 32'(i), 4'hF, rob_tag_t'(i), 1'b0);
        end
        check_eq("t2_full", full, 1);
        alloc(32'h900, 32'h99, 4'hF, 5'd8, 1'b0);
        check_eq("t2_full_after_drop", full, 1);
        commit(5'd0);
        check_eq("t2_head_data", dcif.dc_data_o, 32'h50);
        ack();
        check_eq("t2_not_full", full,          0);
        check_eq("t2_next_req", dcif.dc_req_o, 0);
        for (int i = 1; i < 8; i++) commit(rob_tag_t'(i));
        check_eq("t2_mismatch0", cm_mismatch,    0);
        check_eq("t2_req",       dcif.dc_req_o,  1);
        check_eq("t2_addr",      dcif.dc_addr_o, 32'h104);
        dcif.dc_ack_i = 1'b1;
        repeat (6) tick();
        check_eq("t2_last_data", dcif.dc_data_o, 32'h57);
        tick();
        dcif.dc_ack_i = 1'b0;
        check_eq("t2_drained", empty, 1);

        // ---- forwarding, youngest match wins (pointers now wrapped) ----
        alloc(32'h2000, 32'h11,   4'h3, 5'd9,  1'b0);
        alloc(32'h2002, 32'h2200, 4'hC, 5'd10, 1'b0);
        search(32'h2000, 4'hF);
        check_eq("t3_hit",  fwd_hit,  1);
        check_eq("t3_data", fwd_data, 32'h2200);
        check_eq("t3_mask", fwd_mask, 4'hC);
        search(32'h2001, 4'h3);
        check_eq("t3_old_hit",  fwd_hit,  1);
        check_eq("t3_old_data", fwd_data, 32'h11);
        check_eq("t3_old_mask", fwd_mask, 4'h3);
        search(32'h2004, 4'hF);
        check_eq("t3_miss_hit",  fwd_hit,  0);
        check_eq("t3_miss_data", fwd_data, 0);
        flush = 1'b1; tick(); flush = 1'b0;
        check_eq("t3_flushed", empty, 1);
        search(32'h2000, 4'hF);
        check_eq("t3_flush_miss", fwd_hit, 0);

        // ---- flush with same-cycle commit and dropped allocate ----
        alloc(32'h3000, 32'h31, 4'hF, 5'd1, 1'b0);
        alloc(32'h3004, 32'h32, 4'hF, 5'd2, 1'b0);
        alloc(32'h3008, 32'h33, 4'hF, 5'd3, 1'b0);
        commit(5'd1);
        flush = 1'b1; cm_valid = 1'b1; cm_tag = 5'd2;
        instr_valid = 1'b1; st_alloc = 1'b1; st_addr = 32'h300C; st_data = 32'h34; st_tag = 5'd4;
        tick();
        flush = 1'b0; cm_valid = 1'b0; instr_valid = 1'b0; st_alloc = 1'b0;
        check_eq("t4_mismatch0", cm_mismatch, 0);
        search(32'h3008, 4'hF);
        check_eq("t4_e3_gone", fwd_hit, 0);
        search(32'h300C, 4'hF);
        check_eq("t4_alloc_dropped", fwd_hit, 0);
        check_eq("t4_req1",  dcif.dc_req_o,  1);
        check_eq("t4_addr1", dcif.dc_addr_o, 32'h3000);
        ack();
        check_eq("t4_req2",  dcif.dc_req_o,  1);
        check_eq("t4_addr2", dcif.dc_addr_o, 32'h3004);
        ack();
        check_eq("t4_empty", empty, 1);

        // ---- non-idempotent flag lifetime ----
        alloc(32'h4000, 32'h44, 4'hF, 5'd5, 1'b1);
        check_eq("t5_ni_set", ni_exists, 1);
        tick();
        check_eq("t5_ni_hold", ni_exists, 1);
        commit(5'd5);
        check_eq("t5_ni_committed", ni_exists, 1);
        ack();
        check_eq("t5_ni_clear", ni_exists, 0);

        // ---- commit tag mismatch, and commit with nothing uncommitted ----
        alloc(32'h5002, 32'h55, 4'h4, 5'd4, 1'b0);
        commit(5'd7);
        check_eq("t6_mismatch",  cm_mismatch,    1);
        check_eq("t6_committed", dcif.dc_req_o,  1);
        check_eq("t6_addr",      dcif.dc_addr_o, 32'h5000);
        tick();
        check_eq("t6_pulse_once", cm_mismatch, 0);
        ack();
        check_eq("t6_empty", empty, 1);
        commit(5'd2);
        check_eq("t6_empty_commit", cm_mismatch, 1);
        tick();
        check_eq("t6_empty_pulse_end", cm_mismatch, 0);
        check_eq("t6_still_empty",     empty,       1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_store_commit_buffer
`default_nettype wire

// File: doc/store_commit_buffer.md
Name: store_commit_buffer

Overview:
- In-order FIFO of executed stores that sits directly downstream of the LSU stage and receives its store allocations.
- Holds each store until the ROB commits it, then drains committed stores to the D-cache one at a time over a req/ack handshake.
- Forwards data to younger loads from the youngest matching entry.
- Reports whether any buffered store targets a non-idempotent region, so the AGU can serialise such accesses.

Parameters:
- SB_DEPTH, 8, number of entries; power of two, minimum 2.
- XLEN, 32, address and data width.
- ROB_TAG_W, 5, ROB tag width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- flush_i  in  1  pipeline flush; discards all uncommitted entries
- instr_valid_i  in  1  LSU output is valid this cycle
- store_allocate_i  in  1  allocate a store this cycle
- store_allocate_addr_i  in  XLEN  byte address
- store_allocate_data_i  in  XLEN  lane-aligned store data
- store_allocate_mask_i  in  XLEN/8  byte mask
- store_allocate_rob_tag_i  in  ROB_TAG_W  ROB tag of the store
- store_non_idempotent_region_i  in  1  store targets a non-idempotent region
- commit_valid_i  in  1  ROB retires a store this cycle
- commit_rob_tag_i  in  ROB_TAG_W  tag of the retiring store
- sb_load_find_addr_i  in  XLEN  load address to search
- sb_load_find_mask_i  in  XLEN/8  load byte mask
- sb_load_forward_hit_o  out  1  a matching entry exists
- sb_load_forward_data_o  out  XLEN  data of the youngest match
- sb_load_forward_mask_o  out  XLEN/8  overlap mask (entry mask AND find mask)
- non_idempotent_instr_exists_o  out  1  a valid entry has its non-idempotent bit set
- full_o  out  1  no free entry
- empty_o  out  1  no valid entry
- commit_mismatch_o  out  1  one-cycle pulse on a commit tag mismatch
- dc_req_o  out  1  drain request
- dc_addr_o  out  XLEN  drain address, word-aligned
- dc_data_o  out  XLEN  drain data
- dc_mask_o  out  XLEN/8  drain byte mask
- dc_ack_i  in  1  D-cache has accepted the drain request

Behaviour:
- State is held in three pointers, each with one extra wrap bit: head (oldest entry), cmt (oldest uncommitted entry), tail (next free entry).
- Each entry holds: valid, committed, addr, data, mask, tag, nonidem.
- Reset values: all entries invalid; all pointers 0; empty_o=1; full_o, dc_req_o, sb_load_forward_hit_o, commit_mismatch_o and non_idempotent_instr_exists_o all 0; data, addr and mask outputs 0.
- full_o = (tail == head with the wrap bits differing). empty_o = (tail == head).
- Allocate:
  - Occurs when instr_valid_i && store_allocate_i && !full_o && !flush_i.
  - The entry is written at tail and tail increments; the entry is visible in the following cycle.
  - An allocate while full is dropped; the LSU must stall on full_o.
- Commit:
  - When commit_valid_i is high and cmt != tail, the entry at cmt is marked committed and cmt increments.
  - If that entry's tag != commit_rob_tag_i, the entry is still marked committed and commit_mismatch_o pulses high the next cycle.
  - A commit with no uncommitted entry is ignored and also pulses commit_mismatch_o.
- Flush:
  - tail is set to cmt and all uncommitted entries are invalidated.
  - A commit in the same cycle is applied first, so the committed store survives.
  - An allocate in the same cycle is dropped.
  - Committed entries and any drain in flight are unaffected.
- Drain:
  - dc_req_o = head entry valid && committed. It is a registered-state decode, not a flop on the path.
  - While dc_req_o is high, the payload is driven from the head entry and stays stable until dc_ack_i.
  - dc_ack_i while dc_req_o is high pops head in that cycle. The next head may request in the next cycle, so the peak rate is 1 store per cycle.
  - dc_ack_i without dc_req_o is ignored.
- Allocate, commit and drain-pop may all occur in the same cycle. When full, a pop does not free space for a same-cycle allocate; full_o is based on registered pointers.
- Load forward (combinational):
  - An entry matches when it is valid, addr[XLEN-1:2] equals find_addr[XLEN-1:2], and (mask & find_mask) != 0.
  - Matching is priority-encoded youngest-first, starting from tail-1 and wrapping around to head.
  - sb_load_forward_hit_o, sb_load_forward_data_o and sb_load_forward_mask_o come from the youngest match.
  - With no match, hit is 0 and data and mask are 0.
  - Partial coverage is reported through the mask; merging is done by the LSU.
- non_idempotent_instr_exists_o is the OR over all entries of (valid & nonidem), registered, so it carries one cycle of latency.
- Wrap-around: pointers wrap modulo SB_DEPTH; the wrap bit disambiguates full from empty.

Decomposition:
- The following belong in the shared package: the sb_entry_t struct (valid, committed, addr, data, mask, rob_tag_t, nonidem), SB_DEPTH, and sb_ptr_t (clog2(SB_DEPTH)+1 bits). xlen_data_t, byte_mask_t and rob_tag_t already exist there.
- Sub-module: sb_forward_search, the combinational youngest-first match and select over the entry array, taking tail as the priority start.

Test Plan:
- Reset, then allocate 0x1000/0xAABBCCDD/0xF/tag 3, then commit tag 3 -> dc_req_o=1 with addr 0x1000, data 0xAABBCCDD, mask 0xF; hold dc_ack_i low for 3 cycles -> payload stable; ack -> empty_o=1 next cycle.
- Allocate 8 stores with no commit -> full_o=1; a 9th allocate is dropped; commit and ack one -> full_o=0 next cycle.
- Allocate 0x2000 mask 0x3 data 0x11, then 0x2002 mask 0xC data 0x2200; search 0x2000 mask 0xF -> hit=1, data 0x2200, mask 0xC (youngest).
- Allocate tags 1, 2, 3; commit tag 1; assert flush_i and commit tag 2 in the same cycle -> entries 1 and 2 remain and drain, entry 3 is gone, tail equals cmt.
- Allocate with the non-idempotent bit set -> non_idempotent_instr_exists_o=1 one cycle later, and it stays high until that entry is acked.
- Commit tag 7 while the oldest uncommitted tag is 4 -> commit_mismatch_o pulses once and the entry is marked committed.
